// File: rtl/tm1638_burst_if.sv
// Bus between the LED/key register block (master) and the TM1638 burst engine (slave).
// With TM1638_BURST_AUTOINC_EN defined, the bus also carries the 4-bit display address.
interface tm1638_burst_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic             rw;
  logic [7:0]       cmd;
  logic [LEN_W-1:0] len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             stb;
  logic             sclk;
  logic             dio_in;
  logic             dio_out;
  logic             dio_oe;
`ifdef TM1638_BURST_AUTOINC_EN
  logic [3:0]       addr;

  modport master (
    output start, rw, cmd, len, addr, wr_data, wr_valid, dio_in,
    input  wr_ready, rd_data, rd_valid, busy, done, stb, sclk, dio_out, dio_oe
  );
  modport slave (
    input  start, rw, cmd, len, addr, wr_data, wr_valid, dio_in,
    output wr_ready, rd_data, rd_valid, busy, done, stb, sclk, dio_out, dio_oe
  );
`else
  modport master (
    output start, rw, cmd, len, wr_data, wr_valid, dio_in,
    input  wr_ready, rd_data, rd_valid, busy, done, stb, sclk, dio_out, dio_oe
  );
  modport slave (
    input  start, rw, cmd, len, wr_data, wr_valid, dio_in,
    output wr_ready, rd_data, rd_valid, busy, done, stb, sclk, dio_out, dio_oe
  );
`endif
endinterface

// File: rtl/tm1638_burst.sv
// TM1638 transaction engine: STB frame, command byte, then 0..MAX_LEN data bytes either way.
// Define TM1638_BURST_AUTOINC_EN for a second write frame carrying 0xC0|addr before the data.
module tm1638_burst #(
  parameter int HALF_DIV = 3,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int STB_GAP  = 2,
  parameter int RD_GAP   = 12
) (
  input  logic          clk,
  input  logic          rst,
  tm1638_burst_if.slave bus
);
  localparam int BIT_LEN = 2 * HALF_DIV;
  localparam int CNT_MAX = (BIT_LEN > STB_GAP) ? ((BIT_LEN > RD_GAP) ? BIT_LEN : RD_GAP)
                                               : ((STB_GAP > RD_GAP) ? STB_GAP : RD_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;
  localparam logic [2:0] S_DATA  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;
  localparam logic [2:0] S_FGAP  = 3'd7;

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       rx_reg;
  logic [7:0]       rx_next;
  logic [LEN_W-1:0] bytes_reg;
  logic [LEN_W-1:0] len_clamped;
  logic             rw_reg;
  logic             frame2_reg;
  logic             stb_reg;
  logic             sclk_reg;
  logic             dio_out_reg;
  logic             dio_oe_reg;
  logic [7:0]       rd_data_reg;
  logic             rd_valid_reg;
  logic             done_reg;
`ifdef TM1638_BURST_AUTOINC_EN
  logic [3:0]       addr_reg;
`endif

  assign rx_next     = {bus.dio_in, rx_reg[7:1]};
  assign len_clamped = (bus.len > MAX_LEN_V) ? MAX_LEN_V : bus.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      rx_reg       <= '0;
      bytes_reg    <= '0;
      rw_reg       <= 1'b0;
      frame2_reg   <= 1'b0;
      stb_reg      <= 1'b1;
      sclk_reg     <= 1'b1;
      dio_out_reg  <= 1'b0;
      dio_oe_reg   <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
`ifdef TM1638_BURST_AUTOINC_EN
      addr_reg     <= '0;
`endif
    end else begin
      rd_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // done_reg high means this is the enforced STB-high cycle after a frame
          if (bus.start && !done_reg) begin
            rw_reg    <= bus.rw;
            shift_reg <= bus.cmd;
            bytes_reg <= len_clamped;
            stb_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= S_SETUP;
`ifdef TM1638_BURST_AUTOINC_EN
            frame2_reg <= bus.rw && (len_clamped != '0);
            addr_reg   <= bus.addr;
`else
            frame2_reg <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_reg == CNT_W'(STB_GAP - 1)) begin
            cnt_reg     <= '0;
            bit_reg     <= '0;
            sclk_reg    <= 1'b0;
            dio_oe_reg  <= 1'b1;
            dio_out_reg <= shift_reg[0];
            state_reg   <= S_CMD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_CMD, S_DATA: begin
          if (cnt_reg == CNT_W'(HALF_DIV - 1))
            sclk_reg <= 1'b1;
          if (cnt_reg != CNT_W'(BIT_LEN - 1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end else begin
            cnt_reg <= '0;
            rx_reg  <= rx_next;
            if (bit_reg != 3'd7) begin
              bit_reg     <= bit_reg + 3'd1;
              sclk_reg    <= 1'b0;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              dio_out_reg <= dio_oe_reg & shift_reg[1];
            end else if (state_reg == S_CMD) begin
              if (bytes_reg == '0 || frame2_reg) begin
                dio_oe_reg  <= 1'b0;
                dio_out_reg <= 1'b0;
                state_reg   <= S_HOLD;
              end else if (rw_reg) begin
                state_reg <= S_LOAD;
              end else begin
                dio_oe_reg  <= 1'b0;
                dio_out_reg <= 1'b0;
                state_reg   <= S_GAP;
              end
            end else begin
              if (!rw_reg) begin
                rd_data_reg  <= rx_next;
                rd_valid_reg <= 1'b1;
              end
              bytes_reg <= bytes_reg - LEN_W'(1);
              if (bytes_reg == LEN_W'(1)) begin
                dio_oe_reg  <= 1'b0;
                dio_out_reg <= 1'b0;
                state_reg   <= S_HOLD;
              end else if (rw_reg) begin
                state_reg <= S_LOAD;
              end else begin
                bit_reg  <= '0;
                sclk_reg <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          if (cnt_reg == CNT_W'(RD_GAP - 1)) begin
            cnt_reg   <= '0;
            bit_reg   <= '0;
            sclk_reg  <= 1'b0;
            state_reg <= S_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_LOAD: begin
          // a stall simply parks here with sclk high and dio_out frozen
          if (bus.wr_valid) begin
            shift_reg   <= bus.wr_data;
            dio_out_reg <= bus.wr_data[0];
            sclk_reg    <= 1'b0;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            state_reg   <= S_DATA;
          end
        end
        S_HOLD: begin
          if (cnt_reg == CNT_W'(STB_GAP - 1)) begin
            cnt_reg <= '0;
            stb_reg <= 1'b1;
            if (frame2_reg) begin
              frame2_reg <= 1'b0;
              state_reg  <= S_FGAP;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
`ifdef TM1638_BURST_AUTOINC_EN
          if (cnt_reg == CNT_W'(STB_GAP - 1)) begin
            cnt_reg   <= '0;
            stb_reg   <= 1'b0;
            shift_reg <= {4'hC, addr_reg};
            state_reg <= S_SETUP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`else
          state_reg <= S_IDLE;
`endif
        end
      endcase
    end
  end

  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.wr_ready = (state_reg == S_LOAD);
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.done     = done_reg;
  assign bus.stb      = stb_reg;
  assign bus.sclk     = sclk_reg;
  assign bus.dio_out  = dio_out_reg;
  assign bus.dio_oe   = dio_oe_reg;
endmodule
